// File: rtl/breakpoint_unit.sv
// Instruction breakpoint stage: NBP armed PC comparators feeding a
// request/ack handshake toward the exception controller.
//
// Ports:
//   clk, reset (async, active-low)
//   wr_en/wr_idx/wr_addr/wr_arm : slot programming
//   pc/pc_valid                 : fetched instruction
//   exc_ack                     : exception controller took the request
//   bp_req/bp_idx/bp_pc         : request, winning slot, captured PC
//   bp_armed                    : arm bit per slot
//   hit_count                   : saturating accepted-hit counter
module breakpoint_unit #(
  parameter int N   = 64,
  parameter int NBP = 4,
  parameter int CW  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [$clog2(NBP)-1:0] wr_idx,
  input  logic [N-1:0]           wr_addr,
  input  logic                   wr_arm,
  input  logic [N-1:0]           pc,
  input  logic                   pc_valid,
  input  logic                   exc_ack,
  output logic                   bp_req,
  output logic [$clog2(NBP)-1:0] bp_idx,
  output logic [N-1:0]           bp_pc,
  output logic [NBP-1:0]         bp_armed,
  output logic [CW-1:0]          hit_count
);

  localparam int IW = $clog2(NBP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    MASK    = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   addr_q [NBP];
  logic [NBP-1:0] hit;
  logic           any_hit;
  logic [IW-1:0]  win;
  logic           capture;

  // comp_n per slot: exact full-width equality
  always_comb begin
    hit = '0;
    for (int i = 0; i < NBP; i++) begin
      hit[i] = bp_armed[i] & (addr_q[i] == pc);
    end
  end

  assign any_hit = pc_valid & (|hit);

  // Lowest index wins: scan downward so the last assignment is lowest
  always_comb begin
    win = '0;
    for (int i = NBP - 1; i >= 0; i--) begin
      if (hit[i]) win = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_hit) begin
          state_d = PENDING;
          capture = 1'b1;
        end
      end
      PENDING: begin
        if (exc_ack) state_d = MASK;
      end
      MASK: begin
        // Leaving MASK re-evaluates the new pc as IDLE would
        if (pc_valid && (pc != bp_pc)) begin
          if (any_hit) begin
            state_d = PENDING;
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bp_req    <= 1'b0;
      bp_idx    <= '0;
      bp_pc     <= '0;
      hit_count <= '0;
    end else begin
      state_q <= state_d;
      bp_req  <= (state_d == PENDING);
      if (capture) begin
        bp_idx <= win;
        bp_pc  <= pc;
        if (hit_count != {CW{1'b1}}) begin
          hit_count <= hit_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_armed <= '0;
      for (int i = 0; i < NBP; i++) begin
        addr_q[i] <= '0;
      end
    end else if (wr_en) begin
      bp_armed[wr_idx] <= wr_arm;
      addr_q[wr_idx]   <= wr_addr;
    end
  end

endmodule

// File: tb/tb_breakpoint_unit.sv
// Directed bench for breakpoint_unit: hit, handshake, mask,
// priority, near-miss, PC-zero and async reset mid-request.
module tb_breakpoint_unit;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [63:0] wr_addr;
  logic        wr_arm;
  logic [63:0] pc;
  logic        pc_valid;
  logic        exc_ack;
  logic        bp_req;
  logic [1:0]  bp_idx;
  logic [63:0] bp_pc;
  logic [3:0]  bp_armed;
  logic [7:0]  hit_count;

  int checks = 0;
  int errors = 0;

  breakpoint_unit #(.N(64), .NBP(4), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_addr   (wr_addr),
    .wr_arm    (wr_arm),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .exc_ack   (exc_ack),
    .bp_req    (bp_req),
    .bp_idx    (bp_idx),
    .bp_pc     (bp_pc),
    .bp_armed  (bp_armed),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_slot(input logic [1:0] idx,
                         input logic [63:0] a,
                         input logic arm);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_addr = a;
    wr_arm  = arm;
    tick();
    wr_en   = 1'b0;
  endtask

  localparam logic [63:0] PC_C  = 64'h10CA_C01A_C0CA_C01A;
  localparam logic [63:0] NEAR  = 64'h71AC_ACAC_ACAC_ACAA;
  localparam logic [63:0] NEARP = 64'h71AC_ACAC_ACAC_ACAB;

  initial begin
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_addr  = '0;
    wr_arm   = 1'b0;
    pc       = '0;
    pc_valid = 1'b1;
    exc_ack  = 1'b0;

    #48;
    reset = 1'b1;
    #1;
    chk("rst_req", 64'(bp_req), 64'd0);
    chk("rst_cnt", 64'(hit_count), 64'd0);
    chk("rst_arm", 64'(bp_armed), 64'h0);
    tick();
    tick();
    chk("idle_unarmed_pc0", 64'(bp_req), 64'd0);

    // Single hit and handshake
    pc_valid = 1'b0;
    wr_slot(2'd2, 64'h400, 1'b1);
    chk("arm_s2", 64'(bp_armed), 64'h4);
    pc       = 64'h400;
    pc_valid = 1'b1;
    tick();
    chk("hit_req", 64'(bp_req), 64'd1);
    chk("hit_idx", 64'(bp_idx), 64'd2);
    chk("hit_pc", bp_pc, 64'h400);
    chk("hit_cnt", 64'(hit_count), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", 64'(bp_req), 64'd1);
    end
    chk("hold_cnt", 64'(hit_count), 64'd1);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    chk("ack_req", 64'(bp_req), 64'd0);

    // Mask and re-arm
    tick();
    chk("mask_same_pc", 64'(bp_req), 64'd0);
    pc = 64'h404;
    tick();
    chk("mask_leave", 64'(bp_req), 64'd0);
    pc = 64'h400;
    tick();
    chk("refire_req", 64'(bp_req), 64'd1);
    chk("refire_cnt", 64'(hit_count), 64'd2);
    exc_ack  = 1'b1;
    pc_valid = 1'b0;
    tick();
    exc_ack  = 1'b0;
    chk("ack2_req", 64'(bp_req), 64'd0);

    // Priority and back-to-back
    wr_slot(2'd1, PC_C, 1'b1);
    wr_slot(2'd3, PC_C, 1'b1);
    wr_slot(2'd0, 64'h6000, 1'b1);
    chk("arm_all", 64'(bp_armed), 64'hF);
    chk("mask_pcv0", 64'(bp_req), 64'd0);
    pc       = PC_C;
    pc_valid = 1'b1;
    tick();
    chk("prio_req", 64'(bp_req), 64'd1);
    chk("prio_idx", 64'(bp_idx), 64'd1);
    chk("prio_pc", bp_pc, PC_C);
    chk("prio_cnt", 64'(hit_count), 64'd3);
    exc_ack = 1'b1;
    pc      = 64'h6000;
    tick();
    exc_ack = 1'b0;
    chk("b2b_ack", 64'(bp_req), 64'd0);
    chk("b2b_nocount", 64'(hit_count), 64'd3);
    tick();
    chk("b2b_req", 64'(bp_req), 64'd1);
    chk("b2b_idx", 64'(bp_idx), 64'd0);
    chk("b2b_pc", bp_pc, 64'h6000);
    chk("b2b_cnt", 64'(hit_count), 64'd4);

    // Disarming the hitting slot does not cancel or move the capture
    pc_valid = 1'b0;
    wr_slot(2'd0, 64'h0, 1'b0);
    chk("disarm_arm", 64'(bp_armed), 64'hE);
    chk("disarm_req", 64'(bp_req), 64'd1);
    chk("disarm_idx", 64'(bp_idx), 64'd0);
    chk("disarm_pc", bp_pc, 64'h6000);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    chk("ack3_req", 64'(bp_req), 64'd0);

    // Near-miss and pc_valid gating
    wr_slot(2'd0, NEAR, 1'b1);
    pc       = NEARP;
    pc_valid = 1'b1;
    tick();
    chk("near_miss", 64'(bp_req), 64'd0);
    tick();
    chk("near_miss2", 64'(bp_req), 64'd0);
    pc       = NEAR;
    pc_valid = 1'b0;
    tick();
    chk("pcv0_exact", 64'(bp_req), 64'd0);
    chk("pcv0_cnt", 64'(hit_count), 64'd4);

    // Armed slot at address 0 fires at PC 0
    wr_slot(2'd3, 64'h0, 1'b1);
    pc       = 64'h0;
    pc_valid = 1'b1;
    tick();
    chk("pc0_req", 64'(bp_req), 64'd1);
    chk("pc0_idx", 64'(bp_idx), 64'd3);
    chk("pc0_cnt", 64'(hit_count), 64'd5);

    // Async reset between edges while pending
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", 64'(bp_req), 64'd0);
    chk("arst_cnt", 64'(hit_count), 64'd0);
    chk("arst_arm", 64'(bp_armed), 64'h0);
    chk("arst_pc", bp_pc, 64'h0);
    #10;
    reset = 1'b1;
    tick();
    chk("post_rst_req", 64'(bp_req), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
